// File: rtl/change_dispenser.sv
// Change/refund payout unit: pays a Q1 amount largest coin first from three
// tracked coin stocks, one eject strobe per coin, with done/fault reporting.
module change_dispenser #(
  parameter int unsigned AMT_W      = 6,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               charge_req,
  input  logic [AMT_W-1:0]   amount,
  input  logic               refill,
  output logic               busy,
  output logic               coin_out,
  output logic [1:0]         coin_type,
  output logic               done,
  output logic               fault,
  output logic [AMT_W-1:0]   remaining,
  output logic [STOCK_W-1:0] stock_10,
  output logic [STOCK_W-1:0] stock_1,
  output logic [STOCK_W-1:0] stock_h
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_1  = 2'b01;
  localparam logic [1:0] COIN_H  = 2'b11;

  localparam logic [AMT_W-1:0]   VAL_10 = AMT_W'(20);
  localparam logic [AMT_W-1:0]   VAL_1  = AMT_W'(2);
  localparam logic [AMT_W-1:0]   VAL_H  = AMT_W'(1);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);
  localparam logic [GAP_W-1:0]   GAP_LD = GAP_W'(GAP_CYCLES - 1);

  // S_ZERO is the non-busy pass taken by a zero amount before DONE.
  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_SELECT, S_PULSE, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t           state;
  logic             req_d;
  logic [GAP_W-1:0] gap_cnt;

  logic             req_edge;
  logic             pick_10, pick_1, pick_h;
  logic [AMT_W-1:0] coin_val;

  assign req_edge = charge_req && !req_d;
  assign pick_10  = (remaining >= VAL_10) && (stock_10 != '0);
  assign pick_1   = (remaining >= VAL_1)  && (stock_1  != '0);
  assign pick_h   = (remaining >= VAL_H)  && (stock_h  != '0);

  always_comb begin
    coin_val = VAL_H;
    case (coin_type)
      COIN_10: coin_val = VAL_10;
      COIN_1:  coin_val = VAL_1;
      default: coin_val = VAL_H;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_d     <= 1'b0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      coin_out  <= 1'b0;
      coin_type <= 2'b00;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      stock_10  <= S_INIT;
      stock_1   <= S_INIT;
      stock_h   <= S_INIT;
    end else begin
      req_d    <= charge_req;
      coin_out <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_edge) begin
            remaining <= amount;
            fault     <= 1'b0;
            if (amount == '0) begin
              state <= S_ZERO;
            end else begin
              state <= S_SELECT;
              busy  <= 1'b1;
            end
          end else if (refill) begin
            stock_10 <= S_INIT;
            stock_1  <= S_INIT;
            stock_h  <= S_INIT;
          end
        end
        S_ZERO: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        // Greedy choice: largest coin that fits and is in stock.
        S_SELECT: begin
          if (pick_10 || pick_1 || pick_h) begin
            coin_type <= pick_10 ? COIN_10 : (pick_1 ? COIN_1 : COIN_H);
            coin_out  <= 1'b1;
            state     <= S_PULSE;
          end else begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAULT;
          end
        end
        S_PULSE: begin
          remaining <= remaining - coin_val;
          case (coin_type)
            COIN_10: stock_10 <= stock_10 - STOCK_W'(1);
            COIN_1:  stock_1  <= stock_1  - STOCK_W'(1);
            default: stock_h  <= stock_h  - STOCK_W'(1);
          endcase
          gap_cnt <= GAP_LD;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            if (remaining == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_SELECT;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
